mem_port_ctrl: RTL

- Multicycle memory port controller between the main control FSM and the unified instruction/data RAM.
- Absorbs the PC/ALU-out address mux, the instruction register (IR) and the memory data register (MDR).
- Runs a req/ack handshake toward a variable-latency RAM, checks word alignment and enforces a bus timeout.
- Signals completion with a one-cycle done pulse, so the control FSM waits on done instead of fixed extra memory cycles.

---
 rtl/mem_port_ctrl_if.sv | 35 +++
 rtl/mem_port_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mem_port_ctrl_if
// Brief    : req/ack bus between the memory port controller and the RAM.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface mem_port_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mem_port_ctrl
// Brief    : Multicycle memory port controller (IR/MDR, alignment, timeout).
// Revision : 1.0
// ----------------------------------------------------------------------------
module mem_port_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 16
) (
   input  wire logic        clk,
   input  wire logic        rstb,
   input  wire logic        fetch_req,
   input  wire logic        load_req,
   input  wire logic        store_req,
   input  wire logic [31:0] pc,
   input  wire logic [31:0] alu_out,
   input  wire logic [31:0] write_data,
   output logic      [31:0] instr,
   output logic      [31:0] mdr,
   output logic             busy,
   output logic             done,
   output logic             misalign,
   output logic             bus_err,
   output logic             protocol_err,
   mem_port_ctrl_if.master  mem
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUS  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      K_FETCH = 2'd0,
      K_LOAD  = 2'd1,
      K_STORE = 2'd2
   } kind_t;

   state_t              r_state, w_state_nx;
   kind_t               r_kind,  w_kind_nx;
   logic [CNT_W-1:0]    r_cnt,   w_cnt_nx;
   logic [31:0]         r_instr, w_instr_nx;
   logic [31:0]         r_mdr,   w_mdr_nx;
   logic                r_mem_req, w_mem_req_nx;
   logic                r_mem_we,  w_mem_we_nx;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nx;
   logic [31:0]         r_mem_wdata, w_mem_wdata_nx;
   logic                r_busy, w_busy_nx;
   logic                r_done, w_done_nx;
   logic                r_misalign, w_misalign_nx;
   logic                r_bus_err, w_bus_err_nx;
   logic                r_protocol_err, w_protocol_err_nx;

   logic [1:0]          w_nreq;
   logic [31:0]         w_addr;

   assign w_nreq = 2'(fetch_req) + 2'(load_req) + 2'(store_req);
   assign w_addr = fetch_req ? pc : alu_out;

   always_comb begin
      w_state_nx        = r_state;
      w_kind_nx         = r_kind;
      w_cnt_nx          = r_cnt;
      w_instr_nx        = r_instr;
      w_mdr_nx          = r_mdr;
      w_mem_req_nx      = r_mem_req;
      w_mem_we_nx       = r_mem_we;
      w_mem_addr_nx     = r_mem_addr;
      w_mem_wdata_nx    = r_mem_wdata;
      w_busy_nx         = r_busy;
      w_done_nx         = 1'b0;
      w_misalign_nx     = 1'b0;
      w_bus_err_nx      = 1'b0;
      w_protocol_err_nx = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (w_nreq > 2'd1) begin
               w_protocol_err_nx = 1'b1;
            end else if (w_nreq == 2'd1) begin
               w_kind_nx = fetch_req ? K_FETCH : (load_req ? K_LOAD : K_STORE);
               // Misaligned requests complete immediately without touching the bus.
               if (w_addr[1:0] != 2'b00) begin
                  w_done_nx     = 1'b1;
                  w_misalign_nx = 1'b1;
               end else begin
                  w_mem_req_nx   = 1'b1;
                  w_mem_we_nx    = store_req;
                  w_mem_addr_nx  = w_addr[ADDR_W+1:2];
                  w_mem_wdata_nx = write_data;
                  w_busy_nx      = 1'b1;
                  w_cnt_nx       = '0;
                  w_state_nx     = S_BUS;
               end
            end
         end

         S_BUS: begin
            if (w_nreq != 2'd0) begin
               w_protocol_err_nx = 1'b1;
            end
            // Ack takes priority over a timeout expiring on the same edge.
            if (mem.mem_ack) begin
               w_mem_req_nx = 1'b0;
               w_mem_we_nx  = 1'b0;
               w_busy_nx    = 1'b0;
               w_done_nx    = 1'b1;
               w_state_nx   = S_IDLE;
               if (r_kind == K_FETCH) w_instr_nx = mem.mem_rdata;
               if (r_kind == K_LOAD)  w_mdr_nx   = mem.mem_rdata;
            end else if (r_cnt == C_CNT_LAST) begin
               w_mem_req_nx = 1'b0;
               w_mem_we_nx  = 1'b0;
               w_busy_nx    = 1'b0;
               w_done_nx    = 1'b1;
               w_bus_err_nx = 1'b1;
               w_state_nx   = S_IDLE;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end

         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_state        <= S_IDLE;
         r_kind         <= K_FETCH;
         r_cnt          <= '0;
         r_instr        <= '0;
         r_mdr          <= '0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_misalign     <= 1'b0;
         r_bus_err      <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_kind         <= w_kind_nx;
         r_cnt          <= w_cnt_nx;
         r_instr        <= w_instr_nx;
         r_mdr          <= w_mdr_nx;
         r_mem_req      <= w_mem_req_nx;
         r_mem_we       <= w_mem_we_nx;
         r_mem_addr     <= w_mem_addr_nx;
         r_mem_wdata    <= w_mem_wdata_nx;
         r_busy         <= w_busy_nx;
         r_done         <= w_done_nx;
         r_misalign     <= w_misalign_nx;
         r_bus_err      <= w_bus_err_nx;
         r_protocol_err <= w_protocol_err_nx;
      end
   end

   assign instr         = r_instr;
   assign mdr           = r_mdr;
   assign busy          = r_busy;
   assign done          = r_done;
   assign misalign      = r_misalign;
   assign bus_err       = r_bus_err;
   assign protocol_err  = r_protocol_err;
   assign mem.mem_req   = r_mem_req;
   assign mem.mem_we    = r_mem_we;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
